arith_req_scheduler: RTL and testbench
======================================

# arith_req_scheduler

Sequencer and two-port arbiter in front of the registered arithmetic unit (add/sub/mul/div, one-cycle registered output). It accepts operation requests from two independent requesters and grants them round-robin. It drives the unit's operand, function and enable inputs, captures the registered result, and returns it to the winning requester with an ID tag over a valid/ready response channel. One operation is in flight at a time.

## Interface
Parameters:
- IN_DATA_WIDTH, 16: operand width (A, B).
- OUT_DATA_WIDTH, 2*IN_DATA_WIDTH: result width (Arith_OUT).

Ports:
- CLK  in  1  single clock; all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req0_valid / req1_valid  in  1  request pending from requester 0 / 1.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  IN_DATA_WIDTH  signed operands.
- req0_func / req1_func  in  2  00 add, 01 sub, 10 mul, 11 div.
- A, B  out  IN_DATA_WIDTH  operands to arithmetic unit.
- ALU_FUNC  out  2  function to arithmetic unit.
- Arith_Enable  out  1  enable to arithmetic unit.
- Arith_OUT  in  OUT_DATA_WIDTH  registered result from unit.
- Carry_OUT  in  1  registered carry from unit.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester index of the response.
- rsp_data  out  OUT_DATA_WIDTH  result.
- rsp_carry  out  1  carry.
- rsp_err  out  1  error flag (see Configuration).
- ops_done  out  16  count of completed responses.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: the grant is computed combinationally from the valids and the last_grant register.
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to last_grant wins.
  - The winner's reqN_ready is 1; the other ready is 0. Both readys are 0 in every other state.
  - On accept, latch a, b, func and id into an operand register, update last_grant to id, and go to ISSUE.
- ISSUE: A/B/ALU_FUNC come from the operand register and Arith_Enable=1 for exactly this cycle. Go to CAPTURE.
- CAPTURE: Arith_Enable=0. Load rsp_data←Arith_OUT, rsp_carry←Carry_OUT, rsp_err←0. Go to RESP.
- RESP: rsp_valid=1 with data, id and err stable. When rsp_ready=1: ops_done increments (wraps 0xFFFF→0) and the FSM goes to IDLE.
- A/B/ALU_FUNC always reflect the operand register and are held between operations.
- The scheduler performs no arithmetic; result width and sign rules are those of the unit.

## Timing
- Reset values (async, immediate):
  - State IDLE, last_grant=1 (requester 0 wins the first tie).
  - A=B=0, ALU_FUNC=00, Arith_Enable=0.
  - All readys=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_carry=0, rsp_err=0, ops_done=0.
- Accept in cycle N → Arith_Enable high in N+1 → unit result registered at the end of N+1 → captured at the end of N+2 → rsp_valid high from N+3.
- Minimum spacing between accepts is 4 cycles with rsp_ready tied high.
- Backpressure: with rsp_ready=0, RESP holds indefinitely with all rsp_* stable and no new accepts.
- A requester may drop valid before it is accepted; nothing is latched.
- Reset asserted in any state aborts the operation. No response is produced and the pending request must be re-presented.

## Configuration
- DIV_ZERO_CHECK_EN defined: on accept of func=11 with b=0, the FSM goes directly from IDLE to RESP.
  - Arith_Enable is never asserted.
  - rsp_data=0, rsp_carry=0, rsp_err=1.
  - Response latency is 1 cycle (rsp_valid from N+1).
- DIV_ZERO_CHECK_EN undefined: divide-by-zero is issued like any other operation, rsp_err is tied 0, and rsp_data is whatever the unit produces.

## Test plan
- After reset, req0 a=5, b=3, func=00 → req0_ready in N; rsp_valid in N+3 with rsp_data=8, rsp_id=0, rsp_err=0; Arith_Enable high only in N+1; ops_done=1.
- req0 and req1 both valid continuously (req0: 7,6,func 10; req1: 3,5,func 01) → grants alternate 0,1,0,1; responses 42, −2 (all ones in upper bits), 42, −2.
- rsp_ready held 0 for 10 cycles in RESP → rsp_* stable, readys 0, ops_done unchanged; on release it increments by 1.
- RST pulsed during CAPTURE → all outputs at reset values immediately; no response is ever produced; the next request is served normally, with requester 0 winning the first tie.
- With DIV_ZERO_CHECK_EN: req1 a=9, b=0, func=11 → Arith_Enable stays 0, rsp_valid in N+1, rsp_err=1, rsp_data=0, rsp_id=1. Without the macro: the same request produces Arith_Enable in N+1 and rsp_err=0.
- ops_done preset via 65535 completions → the next completion wraps it to 0.

Source files
------------

// File: rtl/arith_req_scheduler.sv
// ============================================================================
// Module   : arith_req_scheduler
// Function : Round-robin two-port request scheduler in front of a registered
//            add/sub/mul/div unit. One operation in flight at a time. Results
//            return over a valid/ready channel tagged with the requester ID.
// Options  : DIV_ZERO_CHECK_EN - short-circuit divide-by-zero to an error
//            response without issuing it to the unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arith_req_scheduler #(
    parameter int IN_DATA_WIDTH  = 16,
    parameter int OUT_DATA_WIDTH = 2*IN_DATA_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,

    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [IN_DATA_WIDTH-1:0]  req0_a,
    input  logic [IN_DATA_WIDTH-1:0]  req0_b,
    input  logic [1:0]                req0_func,

    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [IN_DATA_WIDTH-1:0]  req1_a,
    input  logic [IN_DATA_WIDTH-1:0]  req1_b,
    input  logic [1:0]                req1_func,

    output logic [IN_DATA_WIDTH-1:0]  A,
    output logic [IN_DATA_WIDTH-1:0]  B,
    output logic [1:0]                ALU_FUNC,
    output logic                      Arith_Enable,
    input  logic [OUT_DATA_WIDTH-1:0] Arith_OUT,
    input  logic                      Carry_OUT,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_id,
    output logic [OUT_DATA_WIDTH-1:0] rsp_data,
    output logic                      rsp_carry,
    output logic                      rsp_err,
    output logic [15:0]               ops_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    localparam logic [1:0] FUNC_DIV = 2'b11;

    state_t                      state_q,      state_d;
    logic                        last_grant_q, last_grant_d;
    logic [IN_DATA_WIDTH-1:0]    op_a_q,       op_a_d;
    logic [IN_DATA_WIDTH-1:0]    op_b_q,       op_b_d;
    logic [1:0]                  op_func_q,    op_func_d;
    logic                        op_id_q,      op_id_d;
    logic [OUT_DATA_WIDTH-1:0]   rsp_data_q,   rsp_data_d;
    logic                        rsp_carry_q,  rsp_carry_d;
    logic                        rsp_err_q,    rsp_err_d;
    logic [15:0]                 ops_done_q,   ops_done_d;

    logic                        w_any_valid;
    logic                        w_grant_id;
    logic [IN_DATA_WIDTH-1:0]    w_sel_a;
    logic [IN_DATA_WIDTH-1:0]    w_sel_b;
    logic [1:0]                  w_sel_func;
    logic                        w_div_zero;

    // On a tie the requester that did not win last time is served.
    assign w_any_valid = req0_valid | req1_valid;
    assign w_grant_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign w_sel_a     = w_grant_id ? req1_a    : req0_a;
    assign w_sel_b     = w_grant_id ? req1_b    : req0_b;
    assign w_sel_func  = w_grant_id ? req1_func : req0_func;

`ifdef DIV_ZERO_CHECK_EN
    assign w_div_zero = (w_sel_func == FUNC_DIV) && (w_sel_b == '0);
`else
    assign w_div_zero = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_func_d    = op_func_q;
        op_id_d      = op_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_err_d    = rsp_err_q;
        ops_done_d   = ops_done_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        Arith_Enable = 1'b0;
        rsp_valid    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_any_valid) begin
                    req0_ready   = ~w_grant_id;
                    req1_ready   = w_grant_id;
                    op_a_d       = w_sel_a;
                    op_b_d       = w_sel_b;
                    op_func_d    = w_sel_func;
                    op_id_d      = w_grant_id;
                    last_grant_d = w_grant_id;
                    if (w_div_zero) begin
                        // Error response is produced locally; the unit is never enabled.
                        rsp_data_d  = '0;
                        rsp_carry_d = 1'b0;
                        rsp_err_d   = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                Arith_Enable = 1'b1;
                state_d      = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                rsp_data_d  = Arith_OUT;
                rsp_carry_d = Carry_OUT;
                rsp_err_d   = 1'b0;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    ops_done_d = ops_done_q + 16'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_func_q    <= 2'b00;
            op_id_q      <= 1'b0;
            rsp_data_q   <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            ops_done_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_func_q    <= op_func_d;
            op_id_q      <= op_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_err_q    <= rsp_err_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign A         = op_a_q;
    assign B         = op_b_q;
    assign ALU_FUNC  = op_func_q;
    assign rsp_id    = op_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_err   = rsp_err_q;
    assign ops_done  = ops_done_q;

endmodule

`default_nettype wire

// File: tb/tb_arith_req_scheduler.sv
// ============================================================================
// Module   : tb_arith_req_scheduler
// Function : Directed self-checking bench for arith_req_scheduler with a
//            registered arithmetic-unit model. Honours DIV_ZERO_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arith_req_scheduler;

    localparam int IW = 16;
    localparam int OW = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [IW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]    req0_func = 2'b00, req1_func = 2'b00;
    logic [IW-1:0] A, B;
    logic [1:0]    ALU_FUNC;
    logic          Arith_Enable;
    logic [OW-1:0] Arith_OUT;
    logic          Carry_OUT;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_id;
    logic [OW-1:0] rsp_data;
    logic          rsp_carry, rsp_err;
    logic [15:0]   ops_done;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    arith_req_scheduler #(.IN_DATA_WIDTH(IW), .OUT_DATA_WIDTH(OW)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
        .A(A), .B(B), .ALU_FUNC(ALU_FUNC), .Arith_Enable(Arith_Enable),
        .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .ops_done(ops_done)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Registered arithmetic unit: signed operands, sign-extended result.
    logic signed [OW-1:0] ext_a, ext_b;
    logic        [IW:0]   usum;
    assign ext_a = {{(OW-IW){A[IW-1]}}, A};
    assign ext_b = {{(OW-IW){B[IW-1]}}, B};
    assign usum  = {1'b0, A} + {1'b0, B};

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            Arith_OUT <= '0;
            Carry_OUT <= 1'b0;
        end else if (Arith_Enable) begin
            case (ALU_FUNC)
                2'b00: begin Arith_OUT <= ext_a + ext_b; Carry_OUT <= usum[IW]; end
                2'b01: begin Arith_OUT <= ext_a - ext_b; Carry_OUT <= 1'b0; end
                2'b10: begin Arith_OUT <= ext_a * ext_b; Carry_OUT <= 1'b0; end
                default: begin
                    Arith_OUT <= (B == '0) ? '0 : ext_a / ext_b;
                    Carry_OUT <= 1'b0;
                end
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive point is 1 time unit after the rising edge; sample point 3 later.
    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        #3;
    endtask

    task automatic wait_rsp();
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < 12 && !ok; w++) begin
            nxt();
            smp();
            if (rsp_valid) ok = 1'b1;
        end
        if (!ok) check_eq("rsp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  acc_cyc;
        int  prev_acc;
        bit  found;
        bit  seen;
        logic [15:0] ops_snap;

        // Reset values while reset is held
        #2;
        check_eq("rst_A",        32'(A), 32'd0);
        check_eq("rst_B",        32'(B), 32'd0);
        check_eq("rst_func",     32'(ALU_FUNC), 32'd0);
        check_eq("rst_enable",   32'(Arith_Enable), 32'd0);
        check_eq("rst_readys",   32'({req0_ready, req1_ready}), 32'd0);
        check_eq("rst_rsp",      32'({rsp_valid, rsp_id, rsp_carry, rsp_err}), 32'd0);
        check_eq("rst_data",     rsp_data, 32'd0);
        check_eq("rst_ops_done", 32'(ops_done), 32'd0);
        nxt(); nxt();
        RST = 1'b0;

        // Single add, 5 + 3, latency N+1 enable / N+3 response
        nxt();
        req0_valid = 1'b1; req0_a = 16'd5; req0_b = 16'd3; req0_func = 2'b00;
        smp();
        check_eq("t1_ready0", 32'(req0_ready), 32'd1);
        check_eq("t1_ready1", 32'(req1_ready), 32'd0);
        check_eq("t1_en_N",   32'(Arith_Enable), 32'd0);
        nxt();
        req0_valid = 1'b0;
        smp();
        check_eq("t1_en_N1",  32'(Arith_Enable), 32'd1);
        check_eq("t1_AB",     32'({A, B}), {16'd5, 16'd3});
        check_eq("t1_func",   32'(ALU_FUNC), 32'd0);
        check_eq("t1_rdy_N1", 32'(req0_ready), 32'd0);
        nxt(); smp();
        check_eq("t1_en_N2",  32'(Arith_Enable), 32'd0);
        check_eq("t1_vld_N2", 32'(rsp_valid), 32'd0);
        nxt(); smp();
        check_eq("t1_vld_N3", 32'(rsp_valid), 32'd1);
        check_eq("t1_data",   rsp_data, 32'd8);
        check_eq("t1_id_err", 32'({rsp_id, rsp_err}), 32'd0);
        nxt(); smp();
        check_eq("t1_ops",    32'(ops_done), 32'd1);
        check_eq("t1_vld_N4", 32'(rsp_valid), 32'd0);

        // Reset during CAPTURE aborts the operation
        nxt();
        req1_valid = 1'b1; req1_a = 16'd4; req1_b = 16'd4; req1_func = 2'b10;
        smp();
        check_eq("rc_ready1", 32'(req1_ready), 32'd1);
        nxt();
        req1_valid = 1'b0;
        nxt(); smp();
        RST = 1'b1;
        #1;
        check_eq("rc_AB",     32'({A, B}), 32'd0);
        check_eq("rc_func",   32'(ALU_FUNC), 32'd0);
        check_eq("rc_vld",    32'({rsp_valid, Arith_Enable}), 32'd0);
        check_eq("rc_ops",    32'(ops_done), 32'd0);
        nxt();
        RST = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nxt(); smp();
            if (rsp_valid) seen = 1'b1;
        end
        check_eq("rc_no_rsp", 32'(seen), 32'd0);

        // Both valid continuously: grants alternate 0,1,0,1 spaced 4 cycles
        nxt();
        req0_valid = 1'b1; req0_a = 16'd7; req0_b = 16'd6; req0_func = 2'b10;
        req1_valid = 1'b1; req1_a = 16'd3; req1_b = 16'd5; req1_func = 2'b01;
        prev_acc = 0;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            acc_cyc = 0;
            for (int w = 0; w < 8 && !found; w++) begin
                if (!(k == 0 && w == 0)) nxt();
                smp();
                if (req0_ready || req1_ready) begin
                    found   = 1'b1;
                    acc_cyc = cyc;
                end
            end
            if (!found) check_eq("rr_accept_timeout", 32'd0, 32'd1);
            check_eq("rr_grant", 32'({req0_ready, req1_ready}), (k % 2 == 0) ? 32'd2 : 32'd1);
            if (k > 0) check_eq("rr_spacing", 32'(acc_cyc - prev_acc), 32'd4);
            prev_acc = acc_cyc;
            wait_rsp();
            check_eq("rr_id",   32'(rsp_id), 32'(k % 2));
            check_eq("rr_data", rsp_data, (k % 2 == 0) ? 32'd42 : 32'hFFFF_FFFE);
        end
        nxt();
        req0_valid = 1'b0; req1_valid = 1'b0;
        smp();
        check_eq("rr_ops", 32'(ops_done), 32'd4);

        // Backpressure: RESP holds, no accepts, ops_done frozen
        rsp_ready = 1'b0;
        nxt();
        req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'd2; req0_func = 2'b00;
        smp();
        check_eq("bp_ready0", 32'(req0_ready), 32'd1);
        nxt();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 16'd1; req1_b = 16'd1; req1_func = 2'b00;
        wait_rsp();
        ops_snap = ops_done;
        check_eq("bp_data",  rsp_data, 32'd1);
        check_eq("bp_carry", 32'(rsp_carry), 32'd1);
        for (int i = 0; i < 10; i++) begin
            nxt(); smp();
            check_eq("bp_hold", 32'({rsp_valid, rsp_id, rsp_err, rsp_carry}), 32'b1001);
            check_eq("bp_hold_data", rsp_data, 32'd1);
            check_eq("bp_readys", 32'({req0_ready, req1_ready}), 32'd0);
            check_eq("bp_ops", 32'(ops_done), 32'(ops_snap));
        end
        nxt();
        rsp_ready = 1'b1; req1_valid = 1'b0;
        nxt(); smp();
        check_eq("bp_ops_inc", 32'(ops_done), 32'd5);
        check_eq("bp_vld_off", 32'(rsp_valid), 32'd0);

        // Divide by zero from requester 1
        nxt();
        req1_valid = 1'b1; req1_a = 16'd9; req1_b = 16'd0; req1_func = 2'b11;
        smp();
        check_eq("dz_ready1", 32'(req1_ready), 32'd1);
        nxt();
        req1_valid = 1'b0;
        smp();
`ifdef DIV_ZERO_CHECK_EN
        check_eq("dz_en",   32'(Arith_Enable), 32'd0);
        check_eq("dz_vld",  32'(rsp_valid), 32'd1);
        check_eq("dz_err",  32'(rsp_err), 32'd1);
        check_eq("dz_data", rsp_data, 32'd0);
        check_eq("dz_id",   32'(rsp_id), 32'd1);
`else
        check_eq("dz_en",   32'(Arith_Enable), 32'd1);
        check_eq("dz_vld",  32'(rsp_valid), 32'd0);
        nxt(); nxt(); smp();
        check_eq("dz_vld3", 32'(rsp_valid), 32'd1);
        check_eq("dz_err",  32'(rsp_err), 32'd0);
        check_eq("dz_id",   32'(rsp_id), 32'd1);
`endif
        nxt(); smp();
        check_eq("dz_ops", 32'(ops_done), 32'd6);

        // ops_done wrap: preload 0xFFFF while stalled in RESP
        rsp_ready = 1'b0;
        nxt();
        req0_valid = 1'b1; req0_a = 16'd2; req0_b = 16'd3; req0_func = 2'b10;
        nxt();
        req0_valid = 1'b0;
        wait_rsp();
        check_eq("wr_data", rsp_data, 32'd6);
        force dut.ops_done_q = 16'hFFFF;
        nxt();
        release dut.ops_done_q;
        rsp_ready = 1'b1;
        smp();
        check_eq("wr_pre",  32'(ops_done), 32'h0000_FFFF);
        nxt(); smp();
        check_eq("wr_wrap", 32'(ops_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
